// File: rtl/clreq_sched_if.sv
// L2 cacheline request/response bus between the stream scheduler
// and the L2 port.
interface clreq_sched_if #(
   parameter int sid_width  = 3,
   parameter int clid_width = 4
);
   logic                  o_l2req_v;
   logic                  o_l2req_r;
   logic [sid_width-1:0]  o_l2req_sid;
   logic [clid_width-1:0] o_l2req_clid;
   logic                  i_l2rsp_v;
   logic                  i_l2rsp_r;
   logic [sid_width-1:0]  i_l2rsp_sid;

   modport master (
      output o_l2req_v,
      output o_l2req_sid,
      output o_l2req_clid,
      input  o_l2req_r,
      input  i_l2rsp_v,
      input  i_l2rsp_sid,
      output i_l2rsp_r
   );

   modport slave (
      input  o_l2req_v,
      input  o_l2req_sid,
      input  o_l2req_clid,
      output o_l2req_r,
      output i_l2rsp_v,
      output i_l2rsp_sid,
      input  i_l2rsp_r
   );
endinterface

// File: rtl/clreq_sched.sv
// Round-robin L2 cacheline-request scheduler with credit limiting
// and per-stream response routing.
module clreq_sched #(
   parameter int nstreams   = 8,
   parameter int ncl        = 16,
   parameter int clid_width = $clog2(ncl),
   parameter int sid_width  = $clog2(nstreams),
   parameter int max_out    = 4,
   parameter int out_width  = $clog2(max_out + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   clreq_sched_if.master        l2,
   input  logic [nstreams-1:0]  i_clreq_v,
   output logic [nstreams-1:0]  i_clreq_r,
   input  logic [nstreams-1:0]  i_srst,
   output logic [nstreams-1:0]  o_clrsp_v,
   input  logic [nstreams-1:0]  o_clrsp_r,
   output logic [out_width-1:0] o_out_cnt,
   output logic                 o_err
);

   localparam logic [out_width-1:0] MaxOut = out_width'(max_out);
   localparam logic [sid_width-1:0] LastSid = sid_width'(nstreams - 1);

   logic [sid_width-1:0]  ptr;
   logic [sid_width-1:0]  win;
   logic [clid_width-1:0] wclid [nstreams];
   logic                  found;
   logic                  grant;
   logic                  free;
   logic                  rsp_ok;
   logic                  rsp_acc;
   logic                  dec;
   logic                  err_set;
   logic [out_width-1:0]  cnt_dec;

   assign rsp_ok  = int'(l2.i_l2rsp_sid) < nstreams;
   assign rsp_acc = l2.i_l2rsp_v & l2.i_l2rsp_r;
   assign dec     = rsp_acc & rsp_ok & (o_out_cnt != '0);
   assign cnt_dec = o_out_cnt - out_width'(dec);
   assign free    = ~l2.o_l2req_v | l2.o_l2req_r;
   assign grant   = found & free & (cnt_dec < MaxOut);

   // out-of-range sids are swallowed so a bad response cannot stall L2
   assign err_set = (l2.i_l2rsp_v & ~rsp_ok) |
                    (rsp_acc & rsp_ok & (o_out_cnt == '0));

   always_comb begin
      o_clrsp_v    = '0;
      l2.i_l2rsp_r = 1'b1;
      if (rsp_ok) begin
         l2.i_l2rsp_r                  = o_clrsp_r[l2.i_l2rsp_sid];
         o_clrsp_v[l2.i_l2rsp_sid]     = l2.i_l2rsp_v;
      end
   end

   always_comb begin : arb
      int                   j;
      logic [sid_width-1:0] idx;
      j     = 0;
      idx   = '0;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < nstreams; i++) begin
         j = int'(ptr) + i;
         if (j >= nstreams) j = j - nstreams;
         idx = sid_width'(j);
         if (!found && i_clreq_v[idx] && !i_srst[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      i_clreq_r = '0;
      if (grant) i_clreq_r[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr             <= '0;
         o_out_cnt       <= '0;
         o_err           <= 1'b0;
         l2.o_l2req_v    <= 1'b0;
         l2.o_l2req_sid  <= '0;
         l2.o_l2req_clid <= '0;
      end else begin
         o_out_cnt <= cnt_dec + out_width'(grant);
         o_err     <= o_err | err_set;
         if (grant) begin
            l2.o_l2req_v    <= 1'b1;
            l2.o_l2req_sid  <= win;
            l2.o_l2req_clid <= wclid[win];
            ptr             <= (win == LastSid) ? '0 : win + 1'b1;
         end else if (l2.o_l2req_r) begin
            l2.o_l2req_v <= 1'b0;
         end
      end
   end

   // stream reset beats a same-cycle grant increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < nstreams; s++) wclid[s] <= '0;
      end else begin
         for (int s = 0; s < nstreams; s++) begin
            if (i_srst[s])
               wclid[s] <= '0;
            else if (grant && (win == sid_width'(s)))
               wclid[s] <= wclid[s] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clreq_sched.sv
// Randomized and directed bench for clreq_sched against a
// behavioural scheduler model.
module tb_clreq_sched;

   localparam int N    = 8;
   localparam int NCL  = 16;
   localparam int MAXO = 4;
   localparam int SW   = 3;
   localparam int CW   = 4;
   localparam int OW   = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  clreq_v, clreq_r, srst, clrsp_v, clrsp_r;
   logic [OW-1:0] out_cnt;
   logic          err;

   logic [5:0]    cv6, cr6, sr6, rv6, rr6;
   logic [OW-1:0] cnt6;
   logic          err6;

   int n_cmp = 0;
   int n_bad = 0;

   clreq_sched_if #(.sid_width(SW), .clid_width(CW)) bus ();
   clreq_sched_if #(.sid_width(SW), .clid_width(CW)) bus6 ();

   clreq_sched u_dut (
      .clk       (clk),
      .reset     (reset),
      .l2        (bus.master),
      .i_clreq_v (clreq_v),
      .i_clreq_r (clreq_r),
      .i_srst    (srst),
      .o_clrsp_v (clrsp_v),
      .o_clrsp_r (clrsp_r),
      .o_out_cnt (out_cnt),
      .o_err     (err)
   );

   clreq_sched #(.nstreams(6)) u_dut6 (
      .clk       (clk),
      .reset     (reset),
      .l2        (bus6.master),
      .i_clreq_v (cv6),
      .i_clreq_r (cr6),
      .i_srst    (sr6),
      .o_clrsp_v (rv6),
      .o_clrsp_r (rr6),
      .o_out_cnt (cnt6),
      .o_err     (err6)
   );

   always #5 clk = ~clk;

   // model state
   int m_ptr, m_cnt, m_sid, m_clid;
   int m_wclid [N];
   bit m_err, m_v;
   // per-cycle model results
   int           e_win, e_cnt_after;
   bit           e_l2rsp_r, e_acc, e_inr;
   logic [N-1:0] e_clreq_r, e_clrsp_v;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_ptr = 0; m_cnt = 0; m_err = 0;
      m_v = 0; m_sid = 0; m_clid = 0;
      for (int s = 0; s < N; s++) m_wclid[s] = 0;
   endfunction

   function automatic void model_comb();
      int  best, sid, d;
      bit  free;
      sid       = int'(bus.i_l2rsp_sid);
      e_inr     = sid < N;
      e_l2rsp_r = e_inr ? clrsp_r[sid] : 1'b1;
      e_clrsp_v = '0;
      if (bus.i_l2rsp_v && e_inr) e_clrsp_v[sid] = 1'b1;
      e_acc       = bus.i_l2rsp_v && e_l2rsp_r;
      e_cnt_after = m_cnt;
      if (e_acc && e_inr && m_cnt > 0) e_cnt_after = m_cnt - 1;
      free  = !m_v || bus.o_l2req_r;
      e_win = -1;
      best  = N;
      // closest eligible stream at or after the pointer
      for (int s = 0; s < N; s++) begin
         d = (s - m_ptr + N) % N;
         if (clreq_v[s] && !srst[s] && d < best) begin
            best  = d;
            e_win = s;
         end
      end
      if (!(free && e_cnt_after < MAXO)) e_win = -1;
      e_clreq_r = '0;
      if (e_win >= 0) e_clreq_r[e_win] = 1'b1;
   endfunction

   function automatic void model_update();
      if ((bus.i_l2rsp_v && !e_inr) || (e_acc && e_inr && m_cnt == 0))
         m_err = 1;
      m_cnt = e_cnt_after + ((e_win >= 0) ? 1 : 0);
      if (e_win >= 0) begin
         m_v    = 1;
         m_sid  = e_win;
         m_clid = m_wclid[e_win];
         m_ptr  = (e_win + 1) % N;
      end else if (bus.o_l2req_r) begin
         m_v = 0;
      end
      for (int s = 0; s < N; s++) begin
         if (srst[s]) m_wclid[s] = 0;
         else if (s == e_win) m_wclid[s] = (m_wclid[s] + 1) % NCL;
      end
   endfunction

   // inputs are set just after a falling edge; sample, clock, return
   task automatic step();
      #1;
      model_comb();
      chk("clreq_r", clreq_r, e_clreq_r);
      chk("l2rsp_r", bus.i_l2rsp_r, e_l2rsp_r);
      chk("clrsp_v", clrsp_v, e_clrsp_v);
      chk("l2req_v", bus.o_l2req_v, m_v);
      chk("l2req_sid", bus.o_l2req_sid, m_sid);
      chk("l2req_clid", bus.o_l2req_clid, m_clid);
      chk("out_cnt", out_cnt, m_cnt);
      chk("err", err, m_err);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clreq_v = '0; srst = '0; clrsp_r = '1;
      bus.o_l2req_r = 1'b1;
      bus.i_l2rsp_v = 1'b0;
      bus.i_l2rsp_sid = '0;
      cv6 = '0; sr6 = '0; rr6 = '1;
      bus6.o_l2req_r = 1'b1;
      bus6.i_l2rsp_v = 1'b0;
      bus6.i_l2rsp_sid = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      #1;
      chk("rst_v", bus.o_l2req_v, 0);
      chk("rst_sid", bus.o_l2req_sid, 0);
      chk("rst_clid", bus.o_l2req_clid, 0);
      chk("rst_cnt", out_cnt, 0);
      chk("rst_err", err, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // echo the register as a response so credits recycle every cycle
   task automatic echo_rsp();
      bus.i_l2rsp_v   = bus.o_l2req_v;
      bus.i_l2rsp_sid = bus.o_l2req_sid;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // random traffic, then reset in the middle of it
      for (int c = 0; c < 600; c++) begin
         clreq_v = N'($urandom);
         srst = '0;
         if ($urandom_range(0, 11) == 0) srst[$urandom_range(0, N-1)] = 1'b1;
         bus.o_l2req_r = ($urandom_range(0, 3) != 0);
         bus.i_l2rsp_v = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
         bus.i_l2rsp_sid = SW'($urandom);
         clrsp_r = N'($urandom);
         step();
      end
      do_reset();

      // first grant after reset: lowest valid index, clid 0
      clreq_v = 8'b0010_1100;
      #1 chk("post_rst_r", clreq_r, 8'h04);
      step();
      chk("post_rst_sid", bus.o_l2req_sid, 2);
      chk("post_rst_clid", bus.o_l2req_clid, 0);

      // fairness
      do_reset();
      clreq_v = 8'hFF;
      for (int k = 0; k < 17; k++) begin
         echo_rsp();
         step();
         chk("fair_v", bus.o_l2req_v, 1);
         chk("fair_sid", bus.o_l2req_sid, k % 8);
         chk("fair_clid", bus.o_l2req_clid, k / 8);
      end

      // credit limit
      do_reset();
      clreq_v = 8'h01;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("cred_clid", bus.o_l2req_clid, k);
      end
      #1;
      chk("cred_block_r", clreq_r, 8'h00);
      chk("cred_cnt", out_cnt, 4);
      step();
      bus.i_l2rsp_v = 1'b1;
      bus.i_l2rsp_sid = 3'd0;
      #1 chk("cred_free_r", clreq_r, 8'h01);
      step();
      bus.i_l2rsp_v = 1'b0;
      chk("cred_clid4", bus.o_l2req_clid, 4);
      chk("cred_cnt4", out_cnt, 4);

      // backpressure with {3,7} pending
      do_reset();
      clreq_v = 8'h08;
      for (int k = 0; k < 8; k++) begin
         echo_rsp();
         step();
      end
      bus.i_l2rsp_v = 1'b0;
      bus.o_l2req_r = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp_r", clreq_r, 8'h00);
         step();
         chk("bp_v", bus.o_l2req_v, 1);
         chk("bp_sid", bus.o_l2req_sid, 3);
         chk("bp_clid", bus.o_l2req_clid, 7);
      end
      bus.o_l2req_r = 1'b1;
      #1 chk("bp_release_r", clreq_r, 8'h08);
      step();
      chk("bp_next_clid", bus.o_l2req_clid, 8);

      // clid wrap and stream reset
      do_reset();
      clreq_v = 8'h04;
      for (int k = 0; k < 17; k++) begin
         echo_rsp();
         step();
         chk("wrap_clid", bus.o_l2req_clid, k % 16);
      end
      echo_rsp();
      srst = 8'h04;
      #1 chk("srst_r", clreq_r, 8'h00);
      step();
      srst = 8'h00;
      echo_rsp();
      #1 chk("srst_next_r", clreq_r, 8'h04);
      step();
      chk("srst_clid", bus.o_l2req_clid, 0);

      // routing and errors
      do_reset();
      bus.i_l2rsp_v = 1'b1;
      bus.i_l2rsp_sid = 3'd5;
      clrsp_r = 8'hDF;
      #1;
      chk("route_v", clrsp_v, 8'h20);
      chk("route_r", bus.i_l2rsp_r, 0);
      step();
      chk("route_err", err, 0);
      clrsp_r = 8'hFF;
      step();
      chk("zero_cnt_err", err, 1);
      chk("zero_cnt_cnt", out_cnt, 0);
      bus.i_l2rsp_v = 1'b0;
      step();
      step();
      chk("err_sticky", err, 1);

      // six-stream instance: sid 7 is out of range
      chk("n6_err0", err6, 0);
      bus6.i_l2rsp_v = 1'b1;
      bus6.i_l2rsp_sid = 3'd7;
      #1;
      chk("n6_drop_r", bus6.i_l2rsp_r, 1);
      chk("n6_drop_v", rv6, 6'h00);
      @(posedge clk);
      @(negedge clk);
      bus6.i_l2rsp_v = 1'b0;
      chk("n6_err", err6, 1);
      chk("n6_cnt", cnt6, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clreq_sched.md
Name: clreq_sched

Overview:
- Shares the single L2 cacheline-request port among `nstreams` per-stream pointer blocks.
- Round-robin arbitrates their cacheline-request valids and issues one registered L2 request per grant. Each request carries the stream id and that stream's next cacheline-id (write pointer).
- Bounds outstanding L2 requests with a credit counter.
- Routes L2 responses back to the owning stream's response handshake.

Parameters:
- nstreams, 8, number of streams (requesters).
- ncl, 16, cachelines per stream buffer; power of 2.
- clid_width, $clog2(ncl), cacheline-id width.
- sid_width, $clog2(nstreams), stream-id width.
- max_out, 4, maximum L2 requests granted but not yet responded.
- out_width, $clog2(max_out+1), credit counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- i_clreq_v  in  nstreams  per-stream cacheline request valid.
- i_clreq_r  out  nstreams  per-stream grant; one-hot or zero.
- i_srst  in  nstreams  per-stream functional reset pulse (stream reset accepted); clears that stream's write clid.
- o_l2req_v  out  1  L2 request valid.
- o_l2req_r  in  1  L2 request ready.
- o_l2req_sid  out  sid_width  stream id of the request.
- o_l2req_clid  out  clid_width  destination cacheline id in the stream buffer.
- i_l2rsp_v  in  1  L2 response valid.
- i_l2rsp_r  out  1  L2 response ready.
- i_l2rsp_sid  in  sid_width  stream id of the response.
- o_clrsp_v  out  nstreams  per-stream response valid.
- o_clrsp_r  in  nstreams  per-stream response ready.
- o_out_cnt  out  out_width  current outstanding count (debug/perf).
- o_err  out  1  sticky protocol error.

Behaviour:
- **Reset** (reset low, asynchronous; all outputs deassert immediately):
  - o_l2req_v=0, o_l2req_sid=0, o_l2req_clid=0.
  - Round-robin pointer=0, all write clids=0, o_out_cnt=0, o_err=0.
- **Output register:** one-entry register holds {sid, clid}. It is "free" when o_l2req_v=0 or (o_l2req_v & o_l2req_r).
- **Grant condition** (per cycle): register free AND o_out_cnt_next < max_out. o_out_cnt_next is the count after this cycle's response decrement.
- **Arbitration:**
  - Search i_clreq_v from the round-robin pointer upward, wrapping; the first set bit wins.
  - Exactly one i_clreq_r bit is high for the winner (combinational); the grant completes the requester handshake.
  - Streams with i_srst high are masked out of the search this cycle.
  - No grant when no eligible valid.
- **On grant to stream s:**
  - Register loads sid=s and clid=wclid[s]; o_l2req_v=1 next cycle. Latency is 1 cycle from grant to o_l2req_v.
  - wclid[s] increments modulo ncl, wrapping ncl-1 -> 0.
  - Round-robin pointer becomes (s+1) mod nstreams. The pointer is unchanged when there is no grant.
- **Hold:** while o_l2req_v=1 and o_l2req_r=0, sid and clid are held stable and no grant occurs.
- **Credits:**
  - o_out_cnt increments by 1 on grant (credit reserved at grant, not at L2 accept).
  - o_out_cnt decrements by 1 on an accepted response (i_l2rsp_v & i_l2rsp_r).
  - Simultaneous grant and response: count unchanged.
  - A response arriving at count max_out frees a credit for a grant in the same cycle.
- **Response routing** (combinational, 0 latency):
  - o_clrsp_v[k] = i_l2rsp_v & (i_l2rsp_sid==k).
  - i_l2rsp_r = o_clrsp_r[i_l2rsp_sid].
- **Errors** (o_err set, sticky until reset):
  - i_l2rsp_sid >= nstreams with i_l2rsp_v: response is dropped (i_l2rsp_r=1, no o_clrsp_v) and o_err is set.
  - Accepted response while o_out_cnt=0: count saturates at 0 and o_err is set.
- **i_srst[s]:**
  - wclid[s]<=0 the next cycle; i_srst has priority over any increment.
  - Does not touch credits, the round-robin pointer, or a request already in the output register.
- **Mid-operation reset:** the pending request is discarded and credits clear to 0. Environment must not deliver responses for pre-reset requests; such a response sets o_err.

Test Plan:
- Reset: drive reset low mid-traffic -> all outputs 0 immediately. After release, first grant goes to the lowest-index valid stream with clid=0.
- Fairness: i_clreq_v=8'hFF held, o_l2req_r=1, a response returned each cycle after 1-cycle delay -> o_l2req_sid sequence 0,1,...,7,0 with one request per cycle. Each stream's clid goes 0,1,... across rounds.
- Credit limit: max_out=4, i_clreq_v=8'h01, no responses -> exactly 4 grants with clid 0,1,2,3, then i_clreq_r=0 and o_out_cnt=4. One response -> next grant in the same cycle with clid=4, count stays 4.
- Backpressure: o_l2req_r=0 for 5 cycles with request {sid=3, clid=7} pending -> outputs stable, no grants. After o_l2req_r=1 for one cycle -> next grant occurs that same cycle.
- Wrap and stream reset: stream 2 granted 17 times with ncl=16 -> clids 0..15 then 0. Pulse i_srst[2] with i_clreq_v[2]=1 in the same cycle -> no grant to 2; the next grant to 2 carries clid=0.
- Routing and errors:
  - i_l2rsp_sid=5 with o_clrsp_r[5]=0 -> o_clrsp_v=8'h20, i_l2rsp_r=0.
  - Response with count 0 -> o_err=1 and stays 1.
  - With nstreams=6, i_l2rsp_sid=7 -> dropped, o_err=1.
